// File: rtl/memstage.sv
// -----------------------------------------------------------------------------
// memstage
//
// Memory-access pipeline stage sitting between execute and register writeback.
// One execute result is accepted per ex_valid/ex_ready handshake. Non-memory ops
// retire one cycle after capture at full throughput. Aligned loads and stores
// are issued on a req/ready data-memory port and retire the cycle after
// dmem_ready. Misaligned loads and stores never reach the bus; they retire the
// next cycle with mem_misalign set and no register write. All retirement and
// redirect outputs are registered.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   ex_valid/ready  execute handshake; ex_ready is low while a bus access is open
//   instype         one-hot op class: 0 R, 1 I, 2 store, 3 load, 4 branch,
//                   5 lui, 6 auipc, 7 jal, 8 jalr
//   subtype         one-hot funct3 (bit n = funct3 value n)
//   aluout1         ALU result / memory address / branch or jump target
//   aluout2         store data for stores, {27'b0, rd} otherwise
//   branch          branch-taken flag
//   flush           kills the incoming op (IDLE) or the open access (REQ)
//   dmem_*          data-memory request port; request held until dmem_ready
//   wb_*            registered writeback pulse
//   redirect_*      registered PC redirect pulse (taken branch, jal, jalr)
//   mem_misalign    pulses with wb_valid for a misaligned load or store
// -----------------------------------------------------------------------------
module memstage #(
  parameter int XLEN     = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [9:0]      instype,
  input  logic [7:0]      subtype,
  input  logic [XLEN-1:0] aluout1,
  input  logic [XLEN-1:0] aluout2,
  input  logic            branch,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mem_misalign
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Decode of the op presented by execute
  // ---------------------------------------------------------------------------
  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       any_op;
  logic       writes_rd;
  logic       size_byte;
  logic       size_half;
  logic       misalign;
  logic       accept;
  logic       start_req;
  logic [4:0] rd_in;
  logic [1:0] off_in;

  assign is_load   = instype[3];
  assign is_store  = instype[2];
  assign is_mem    = is_load | is_store;
  assign any_op    = |instype[8:0];
  assign writes_rd = instype[0] | instype[1] | instype[3] | instype[5] | instype[6];
  // funct3 0/4 are byte accesses, 1/5 half-word, anything else a full word.
  assign size_byte = subtype[0] | subtype[4];
  assign size_half = subtype[1] | subtype[5];
  assign rd_in     = aluout2[4:0];
  assign off_in    = aluout1[1:0];

  assign misalign  = is_mem & ((size_half & off_in[0]) |
                               (~size_byte & ~size_half & (|off_in)));

  assign ex_ready  = (state_q == S_IDLE);
  // A flush in the same cycle as a transfer discards the incoming op.
  assign accept    = ex_valid & ex_ready & ~flush;
  assign start_req = accept & is_mem & ~misalign;

  // subtype bits 3/6/7 carry no load/store width and instype[9] is reserved.
  logic unused_inputs;
  assign unused_inputs = ^{subtype[3], subtype[6], subtype[7], instype[9]};

  // ---------------------------------------------------------------------------
  // Store lane formatting for the op presented by execute
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_wdata = aluout2;
    st_wstrb = 4'b1111;
    if (size_byte) begin
      st_wdata = {4{aluout2[7:0]}};
      st_wstrb = 4'b0001 << off_in;
    end else if (size_half) begin
      st_wdata = {2{aluout2[15:0]}};
      st_wstrb = 4'b0011 << off_in;
    end
    if (!is_store) begin
      st_wstrb = 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Captured memory op; these registers drive the bus directly, so address,
  // direction, data and strobes stay stable for the whole REQ phase.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] op_addr;
  logic [XLEN-1:0] op_wdata;
  logic [3:0]      op_wstrb;
  logic            op_store;
  logic            op_byte;
  logic            op_half;
  logic            op_unsigned;
  logic [4:0]      op_rd;
  logic            op_kill;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_addr     <= '0;
      op_wdata    <= '0;
      op_wstrb    <= '0;
      op_store    <= 1'b0;
      op_byte     <= 1'b0;
      op_half     <= 1'b0;
      op_unsigned <= 1'b0;
      op_rd       <= '0;
      op_kill     <= 1'b0;
    end else if (start_req) begin
      op_addr     <= aluout1;
      op_wdata    <= st_wdata;
      op_wstrb    <= st_wstrb;
      op_store    <= is_store;
      op_byte     <= size_byte;
      op_half     <= size_half;
      op_unsigned <= subtype[4] | subtype[5];
      op_rd       <= rd_in;
      op_kill     <= 1'b0;
    end else if (state_q == S_REQ && flush) begin
      // The bus transfer still runs to dmem_ready; only its retirement dies.
      op_kill     <= 1'b1;
    end
  end

  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = op_store;
  assign dmem_addr  = {op_addr[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
  assign dmem_wdata = op_wdata;
  assign dmem_wstrb = op_wstrb;

  // ---------------------------------------------------------------------------
  // Load data extraction: shift the addressed lane down, then extend.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    ld_shift = dmem_rdata >> {op_addr[1:0], 3'b000};
    ld_data  = ld_shift;
    if (op_byte) begin
      ld_data = {{24{~op_unsigned & ld_shift[7]}}, ld_shift[7:0]};
    end else if (op_half) begin
      ld_data = {{16{~op_unsigned & ld_shift[15]}}, ld_shift[15:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and next values of the registered retirement outputs.
  // Pulse outputs default low; payload outputs hold their last value.
  // ---------------------------------------------------------------------------
  logic            ret_valid;
  logic            ret_we;
  logic [4:0]      ret_rd;
  logic [XLEN-1:0] ret_data;
  logic            ret_redir;
  logic [XLEN-1:0] ret_pc;
  logic            ret_mis;

  always_comb begin
    state_d   = state_q;
    ret_valid = 1'b0;
    ret_we    = 1'b0;
    ret_rd    = wb_rd;
    ret_data  = wb_data;
    ret_redir = 1'b0;
    ret_pc    = redirect_pc;
    ret_mis   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_REQ;
        end else if (accept && any_op) begin
          // Non-memory op, or a misaligned load/store that never reaches the bus.
          ret_valid = 1'b1;
          ret_mis   = misalign;
          ret_we    = writes_rd & ~misalign & (rd_in != 5'd0);
          ret_rd    = is_store ? 5'd0 : rd_in;
          ret_data  = aluout1;
          ret_redir = (instype[4] & branch) | instype[7] | instype[8];
          ret_pc    = aluout1;
          if (instype[8]) begin
            ret_pc[0] = 1'b0;
          end
        end
      end

      S_REQ: begin
        if (dmem_ready) begin
          state_d = S_IDLE;
          if (!op_kill && !flush) begin
            ret_valid = 1'b1;
            ret_we    = ~op_store & (op_rd != 5'd0);
            ret_rd    = op_store ? 5'd0 : op_rd;
            ret_data  = op_store ? op_addr : ld_data;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered retirement and redirect outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid       <= 1'b0;
      wb_we          <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mem_misalign   <= 1'b0;
    end else begin
      wb_valid       <= ret_valid;
      wb_we          <= ret_we;
      wb_rd          <= ret_rd;
      wb_data        <= ret_data;
      redirect_valid <= ret_redir;
      redirect_pc    <= ret_pc;
      mem_misalign   <= ret_mis;
    end
  end

endmodule
